// File: rtl/spm_mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spm_mem_arbiter_if
//  Description : Bus bundle for the RISC_SPM memory-port arbiter. Carries the
//                CPU requester port, the host/loader requester port and the
//                single memory-array port.
//
//  Signals (direction seen from the arbiter, i.e. the slave modport):
//    cpu_req/cpu_we/cpu_addr/cpu_wdata      in   CPU request, held until cpu_gnt
//    cpu_gnt/cpu_rvalid/cpu_rdata           out  CPU grant and read return
//    host_req/host_we/host_addr/host_wdata  in   host request, held until host_gnt
//    host_lock                              in   host asks for exclusive ownership
//    host_gnt/host_rvalid/host_rdata        out  host grant and read return
//    mem_en/mem_we/mem_addr/mem_wdata       out  memory access
//    mem_rdata                              in   memory read data (1-cycle latency)
//    cpu_gnt_cnt/host_gnt_cnt               out  grant counters (ARB_STATS_EN only)
//
//  Modports    : master - requesters + memory model side
//                slave  - the arbiter
//
//  Build option: ARB_STATS_EN adds the two 16-bit grant counters.
//
//  Revision    : 1.0 - initial release
// ============================================================================
interface spm_mem_arbiter_if #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 8
);

  // CPU requester
  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADDR_SIZE-1:0] cpu_addr;
  logic [WORD_SIZE-1:0] cpu_wdata;
  logic                 cpu_gnt;
  logic                 cpu_rvalid;
  logic [WORD_SIZE-1:0] cpu_rdata;

  // Host / loader requester
  logic                 host_req;
  logic                 host_we;
  logic [ADDR_SIZE-1:0] host_addr;
  logic [WORD_SIZE-1:0] host_wdata;
  logic                 host_lock;
  logic                 host_gnt;
  logic                 host_rvalid;
  logic [WORD_SIZE-1:0] host_rdata;

  // Memory array port
  logic                 mem_en;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;

`ifdef ARB_STATS_EN
  logic [15:0]          cpu_gnt_cnt;
  logic [15:0]          host_gnt_cnt;
`endif

  modport master (
`ifdef ARB_STATS_EN
    input  cpu_gnt_cnt,
    input  host_gnt_cnt,
`endif
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output host_req, host_we, host_addr, host_wdata, host_lock,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
`ifdef ARB_STATS_EN
    output cpu_gnt_cnt,
    output host_gnt_cnt,
`endif
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  host_req, host_we, host_addr, host_wdata, host_lock,
    output host_gnt, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

`default_nettype wire

// File: rtl/spm_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spm_mem_arbiter
//  Description : Shares the single RISC_SPM memory port between the CPU and a
//                host/loader requester. One access per cycle, reads return a
//                fixed one cycle after the grant. The CPU wins by default, the
//                host is forced through after MAX_WAIT consecutive denied
//                cycles, and the host may lock the port for bursts.
//
//  Ports       : clk  - system clock, rising edge
//                rst  - synchronous, active-high reset
//                bus  - spm_mem_arbiter_if.slave (CPU port, host port,
//                       memory port; see interface header for the list)
//
//  Parameters  : WORD_SIZE - data width (default 8)
//                ADDR_SIZE - address width (default 8, 256 words)
//                MAX_WAIT  - denied host cycles before the host is forced to
//                            win, legal range 1..15 (default 3)
//
//  Build option: ARB_STATS_EN - adds saturating 16-bit grant counters
//                cpu_gnt_cnt / host_gnt_cnt on the interface.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module spm_mem_arbiter #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 8,
  parameter int MAX_WAIT  = 3
) (
  input wire           clk,
  input wire           rst,
  spm_mem_arbiter_if.slave bus
);

  // --------------------------------------------------------------------------
  // Types and constants
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Which requester the read in flight belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_e               r_state;
  logic [3:0]           r_wait_cnt;
  owner_e               r_rd_owner;
  logic [WORD_SIZE-1:0] r_cpu_rdata;   // last data returned to the CPU
  logic [WORD_SIZE-1:0] r_host_rdata;  // last data returned to the host

  // --------------------------------------------------------------------------
  // Combinational arbitration
  // --------------------------------------------------------------------------
  logic                 w_lock_hold;
  logic                 w_cpu_gnt;
  logic                 w_host_gnt;
  logic                 w_mem_we;
  logic [ADDR_SIZE-1:0] w_mem_addr;
  logic [WORD_SIZE-1:0] w_mem_wdata;

  // The lock only holds off the CPU while host_lock is still asserted; in the
  // cycle the host drops it, normal arbitration applies straight away.
  assign w_lock_hold = (r_state == LOCKED) && bus.host_lock;

  always_comb begin
    w_cpu_gnt  = 1'b0;
    w_host_gnt = 1'b0;
    if (!rst) begin
      if (w_lock_hold) begin
        w_host_gnt = bus.host_req;
      end else if (bus.host_req && (r_wait_cnt == c_max_wait)) begin
        // starvation guard: host has been denied long enough
        w_host_gnt = 1'b1;
      end else if (bus.cpu_req) begin
        w_cpu_gnt  = 1'b1;
      end else if (bus.host_req) begin
        w_host_gnt = 1'b1;
      end
    end
  end

  // Memory port mux; everything is driven to zero when nobody is granted.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (w_cpu_gnt) begin
      w_mem_we    = bus.cpu_we;
      w_mem_addr  = bus.cpu_addr;
      w_mem_wdata = bus.cpu_wdata;
    end else if (w_host_gnt) begin
      w_mem_we    = bus.host_we;
      w_mem_addr  = bus.host_addr;
      w_mem_wdata = bus.host_wdata;
    end
  end

  assign bus.cpu_gnt   = w_cpu_gnt;
  assign bus.host_gnt  = w_host_gnt;
  assign bus.mem_en    = w_cpu_gnt | w_host_gnt;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;

  // --------------------------------------------------------------------------
  // State machine, starvation counter and read-owner tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB;
      r_wait_cnt   <= '0;
      r_rd_owner   <= OWN_NONE;
      r_cpu_rdata  <= '0;
      r_host_rdata <= '0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_host_gnt && bus.host_lock) begin
            r_state <= LOCKED;
          end
        end
        LOCKED: begin
          if (!bus.host_lock) begin
            r_state <= ARB;
          end
        end
        default: r_state <= ARB;
      endcase

      // Frozen while the lock holds; otherwise counts consecutive denials.
      if (!w_lock_hold) begin
        if (w_host_gnt || !bus.host_req) begin
          r_wait_cnt <= '0;
        end else if (r_wait_cnt != c_max_wait) begin
          r_wait_cnt <= r_wait_cnt + 4'd1;
        end
      end

      if (w_cpu_gnt && !bus.cpu_we) begin
        r_rd_owner <= OWN_CPU;
      end else if (w_host_gnt && !bus.host_we) begin
        r_rd_owner <= OWN_HOST;
      end else begin
        r_rd_owner <= OWN_NONE;
      end

      // Capture the returned word so each side keeps showing its last read.
      if (r_rd_owner == OWN_CPU) begin
        r_cpu_rdata <= bus.mem_rdata;
      end
      if (r_rd_owner == OWN_HOST) begin
        r_host_rdata <= bus.mem_rdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read return. mem_rdata is already registered inside the memory, so the
  // owner sees it directly in the return cycle. Outputs are forced low while
  // rst is high, which also kills a read granted just before reset.
  // --------------------------------------------------------------------------
  assign bus.cpu_rvalid  = !rst && (r_rd_owner == OWN_CPU);
  assign bus.host_rvalid = !rst && (r_rd_owner == OWN_HOST);

  assign bus.cpu_rdata   = rst                     ? '0            :
                           (r_rd_owner == OWN_CPU)  ? bus.mem_rdata : r_cpu_rdata;
  assign bus.host_rdata  = rst                     ? '0            :
                           (r_rd_owner == OWN_HOST) ? bus.mem_rdata : r_host_rdata;

`ifdef ARB_STATS_EN
  // --------------------------------------------------------------------------
  // Saturating grant counters
  // --------------------------------------------------------------------------
  logic [15:0] r_cpu_gnt_cnt;
  logic [15:0] r_host_gnt_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_gnt_cnt  <= '0;
      r_host_gnt_cnt <= '0;
    end else begin
      if (w_cpu_gnt && (r_cpu_gnt_cnt != 16'hFFFF)) begin
        r_cpu_gnt_cnt <= r_cpu_gnt_cnt + 16'd1;
      end
      if (w_host_gnt && (r_host_gnt_cnt != 16'hFFFF)) begin
        r_host_gnt_cnt <= r_host_gnt_cnt + 16'd1;
      end
    end
  end

  assign bus.cpu_gnt_cnt  = r_cpu_gnt_cnt;
  assign bus.host_gnt_cnt = r_host_gnt_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spm_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_spm_mem_arbiter
//  Description : Self-checking bench for spm_mem_arbiter. Includes a 256-word
//                memory with registered reads and a behavioural model of the
//                arbitration rules, shadow memory and read returns.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spm_mem_arbiter;

  localparam int WORD_SIZE = 8;
  localparam int ADDR_SIZE = 8;
  localparam int MAX_WAIT  = 3;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic mem_init = 1'b1;

  always #5 clk = ~clk;

  spm_mem_arbiter_if #(.WORD_SIZE(WORD_SIZE), .ADDR_SIZE(ADDR_SIZE)) bus ();

  spm_mem_arbiter #(
    .WORD_SIZE(WORD_SIZE),
    .ADDR_SIZE(ADDR_SIZE),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // --------------------------------------------------------------------------
  // Memory array: registered read, writes visible to the next read
  // --------------------------------------------------------------------------
  logic [7:0] mem [256];

  function automatic logic [7:0] init_val(int i);
    return (i == 128) ? 8'd4 : 8'(i * 7 + 3);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      bus.mem_rdata <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model state
  // --------------------------------------------------------------------------
  logic [7:0] ref_mem [256];
  bit         m_locked;
  int         m_wait;
  bit         m_crv, m_hrv;
  logic [7:0] m_crd, m_hrd;
  int         m_ccnt, m_hcnt;

  // values seen in the last step, for directed checks
  bit         seen_cgnt, seen_hgnt, seen_crv, seen_hrv;
  logic [7:0] seen_crd, seen_hrd;
  logic [15:0] seen_ccnt, seen_hcnt;

  // One clock cycle: predict and check at the falling edge, then advance the
  // model with the inputs that were present at the rising edge.
  task automatic step();
    bit         lk, ec, eh, ewe;
    logic [7:0] ea, ed;
    @(negedge clk);
    lk = m_locked && bus.host_lock;
    ec = 1'b0;
    eh = 1'b0;
    if (!rst) begin
      if (lk)                                   eh = bus.host_req;
      else if (bus.host_req && m_wait == MAX_WAIT) eh = 1'b1;
      else if (bus.cpu_req)                     ec = 1'b1;
      else if (bus.host_req)                    eh = 1'b1;
    end
    ewe = ec ? bus.cpu_we   : (eh ? bus.host_we   : 1'b0);
    ea  = ec ? bus.cpu_addr : (eh ? bus.host_addr : 8'h00);
    ed  = ec ? bus.cpu_wdata: (eh ? bus.host_wdata: 8'h00);

    check("cpu_gnt",     32'(bus.cpu_gnt),     32'(ec));
    check("host_gnt",    32'(bus.host_gnt),    32'(eh));
    check("mem_en",      32'(bus.mem_en),      32'(ec | eh));
    check("mem_we",      32'(bus.mem_we),      32'(ewe));
    check("mem_addr",    32'(bus.mem_addr),    32'(ea));
    check("mem_wdata",   32'(bus.mem_wdata),   32'(ed));
    check("cpu_rvalid",  32'(bus.cpu_rvalid),  32'(!rst && m_crv));
    check("host_rvalid", 32'(bus.host_rvalid), 32'(!rst && m_hrv));
    check("cpu_rdata",   32'(bus.cpu_rdata),   rst ? 32'd0 : 32'(m_crd));
    check("host_rdata",  32'(bus.host_rdata),  rst ? 32'd0 : 32'(m_hrd));
`ifdef ARB_STATS_EN
    check("cpu_gnt_cnt",  32'(bus.cpu_gnt_cnt),  32'(m_ccnt));
    check("host_gnt_cnt", 32'(bus.host_gnt_cnt), 32'(m_hcnt));
    seen_ccnt = bus.cpu_gnt_cnt;
    seen_hcnt = bus.host_gnt_cnt;
`endif
    seen_cgnt = bus.cpu_gnt;
    seen_hgnt = bus.host_gnt;
    seen_crv  = bus.cpu_rvalid;
    seen_hrv  = bus.host_rvalid;
    seen_crd  = bus.cpu_rdata;
    seen_hrd  = bus.host_rdata;

    @(posedge clk);
    #1;
    if (rst) begin
      m_locked = 1'b0;
      m_wait   = 0;
      m_crv    = 1'b0;
      m_hrv    = 1'b0;
      m_crd    = 8'h00;
      m_hrd    = 8'h00;
      m_ccnt   = 0;
      m_hcnt   = 0;
    end else begin
      m_crv = ec && !bus.cpu_we;
      if (m_crv) m_crd = ref_mem[bus.cpu_addr];
      m_hrv = eh && !bus.host_we;
      if (m_hrv) m_hrd = ref_mem[bus.host_addr];
      if (ec && bus.cpu_we)  ref_mem[bus.cpu_addr]  = bus.cpu_wdata;
      if (eh && bus.host_we) ref_mem[bus.host_addr] = bus.host_wdata;
      if (!lk) begin
        if (eh || !bus.host_req) m_wait = 0;
        else                     m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      end
      m_locked = bus.host_lock && (lk || eh);
      if (ec && m_ccnt < 65535) m_ccnt++;
      if (eh && m_hcnt < 65535) m_hcnt++;
    end
  endtask

  task automatic set_cpu(bit req, bit we, logic [7:0] a, logic [7:0] d);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
  endtask

  task automatic set_host(bit req, bit we, bit lock, logic [7:0] a, logic [7:0] d);
    bus.host_req   = req;
    bus.host_we    = we;
    bus.host_lock  = lock;
    bus.host_addr  = a;
    bus.host_wdata = d;
  endtask

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    bit cp, hp;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    m_locked = 1'b0; m_wait = 0; m_crv = 1'b0; m_hrv = 1'b0;
    m_crd = 8'h00; m_hrd = 8'h00; m_ccnt = 0; m_hcnt = 0;
    set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    set_host(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    mem_init = 1'b1;
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    mem_init = 1'b0;
    step();

    // CPU read of the preloaded word 128
    set_cpu(1'b1, 1'b0, 8'd128, 8'h00);
    step();
    check("t1_gnt", 32'(seen_cgnt), 32'd1);
    set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    step();
    check("t1_rvalid", 32'(seen_crv), 32'd1);
    check("t1_rdata",  32'(seen_crd), 32'd4);
    check("t1_host_rv", 32'(seen_hrv), 32'd0);

    // Both requesters held: CPU wins until the host has waited MAX_WAIT cycles
    step();
    set_cpu(1'b1, 1'b0, 8'd10, 8'h00);
    set_host(1'b1, 1'b0, 1'b0, 8'd20, 8'h00);
    for (int i = 0; i < 2 * (MAX_WAIT + 1); i++) begin
      step();
      check("t2_seq", 32'({seen_cgnt, seen_hgnt}),
            ((i % (MAX_WAIT + 1)) == MAX_WAIT) ? 32'd1 : 32'd2);
    end
    set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    set_host(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();

    // Locked host burst writes 0..5, CPU kept out, then reads them back
    set_host(1'b1, 1'b1, 1'b1, 8'd0, 8'hA0);
    step();
    check("t3_lock_gnt", 32'(seen_hgnt), 32'd1);
    set_cpu(1'b1, 1'b0, 8'd0, 8'h00);
    for (int i = 1; i < 6; i++) begin
      set_host(1'b1, 1'b1, 1'b1, 8'(i), 8'(8'hA0 + i));
      step();
      check("t3_cpu_blocked", 32'(seen_cgnt), 32'd0);
      check("t3_host_gnt",    32'(seen_hgnt), 32'd1);
    end
    set_host(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    check("t3_unlock_gnt", 32'(seen_cgnt), 32'd1);
    for (int i = 1; i <= 6; i++) begin
      set_cpu(i < 6, 1'b0, 8'(i), 8'h00);
      step();
      check("t3_rvalid", 32'(seen_crv), 32'd1);
      check("t3_rdata",  32'(seen_crd), 32'(8'hA0 + i - 1));
    end

    // Host write then CPU read of the same address on the next cycle
    set_host(1'b1, 1'b1, 1'b0, 8'd139, 8'hF0);
    set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    step();
    set_host(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_cpu(1'b1, 1'b0, 8'd139, 8'h00);
    step();
    check("t4_gnt", 32'(seen_cgnt), 32'd1);
    set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    step();
    check("t4_rvalid", 32'(seen_crv), 32'd1);
    check("t4_rdata",  32'(seen_crd), 32'hF0);

    // Reset right after a locked host read
    set_host(1'b1, 1'b0, 1'b1, 8'd7, 8'h00);
    step();
    check("t5_host_gnt", 32'(seen_hgnt), 32'd1);
    set_host(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    rst = 1'b1;
    step();
    check("t5_hrv_rst", 32'(seen_hrv), 32'd0);
    step();
    rst = 1'b0;
    set_cpu(1'b1, 1'b0, 8'd3, 8'h00);
    set_host(1'b1, 1'b0, 1'b1, 8'd4, 8'h00);
    step();
    check("t5_arb_cpu", 32'(seen_cgnt), 32'd1);
    check("t5_hrv",     32'(seen_hrv),  32'd0);
    set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    set_host(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    step();

`ifdef ARB_STATS_EN
    // Grant counters: 10 CPU and 4 host grants after reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_cpu(1'b1, 1'b1, 8'(50 + i), 8'(i));
      step();
    end
    set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      set_host(1'b1, 1'b1, 1'b0, 8'(70 + i), 8'(i));
      step();
    end
    set_host(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    check("t6_cpu_cnt",  32'(seen_ccnt), 32'd10);
    check("t6_host_cnt", 32'(seen_hcnt), 32'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("t6_cpu_cnt_rst",  32'(seen_ccnt), 32'd0);
    check("t6_host_cnt_rst", 32'(seen_hcnt), 32'd0);
`endif

    // Randomised traffic: requesters hold until granted, lock toggles,
    // occasional reset
    cp = 1'b0;
    hp = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!cp && $urandom_range(0, 2) == 0) begin
        cp = 1'b1;
        set_cpu(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
      end
      if (!hp && $urandom_range(0, 2) == 0) begin
        hp = 1'b1;
        bus.host_req   = 1'b1;
        bus.host_we    = 1'($urandom_range(0, 1));
        bus.host_addr  = 8'($urandom_range(0, 15));
        bus.host_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 7) == 0) bus.host_lock = ~bus.host_lock;
      rst = ($urandom_range(0, 199) == 0);
      step();
      if (seen_cgnt) begin
        cp = 1'b0;
        bus.cpu_req = 1'b0;
      end
      if (seen_hgnt) begin
        hp = 1'b0;
        bus.host_req = 1'b0;
      end
    end
    rst = 1'b0;
    set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    set_host(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
